// File: rtl/fetch_decode_unit.sv
// Instruction fetch and decode front end: fetches one word per instruction,
// holds it while the datapath executes, and advances or redirects the PC.

package fetch_decode_pkg;
  typedef logic [6:0] opcode_t;

  localparam opcode_t OPC_LOAD   = 7'b0000011;
  localparam opcode_t OPC_OP_IMM = 7'b0010011;
  localparam opcode_t OPC_AUIPC  = 7'b0010111;
  localparam opcode_t OPC_STORE  = 7'b0100011;
  localparam opcode_t OPC_OP     = 7'b0110011;
  localparam opcode_t OPC_LUI    = 7'b0110111;
  localparam opcode_t OPC_BRANCH = 7'b1100011;
  localparam opcode_t OPC_JALR   = 7'b1100111;
  localparam opcode_t OPC_JAL    = 7'b1101111;
  localparam opcode_t OPC_HALT   = 7'b1111111;
endpackage

module fetch_decode_unit
  import fetch_decode_pkg::*;
#(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic          CLK,
  input  logic          RST,
  // instruction memory
  output logic          iREN,
  output logic [31:0]   iaddr,
  input  logic [31:0]   iload,
  input  logic          ihit,
  // datapath / control unit
  input  logic          mem_stall,
  output opcode_t       opcode,
  output logic [6:0]    funct7,
  output logic [2:0]    funct3,
  output logic [4:0]    rs1,
  output logic [4:0]    rs2,
  output logic [4:0]    rd,
  output logic [31:0]   imm,
  output logic          instr_valid,
  input  logic          PCSrc,
  input  logic          Jump,
  input  logic          halt,
  input  logic [31:0]   target,
  output logic [31:0]   pc,
  output logic [31:0]   pc_plus4,
  output logic          halted,
  output logic [31:0]   retired
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_EXEC   = 2'd1,
    S_HALTED = 2'd2
  } state_t;

  state_t            r_state;
  logic [XLEN-1:0]   r_pc;
  logic [XLEN-1:0]   r_instr;
  logic [XLEN-1:0]   r_retired;
  logic              r_iren;
  logic              r_valid;
  logic              r_halted;

  logic [XLEN-1:0]   w_pc_plus4;
  logic [XLEN-1:0]   w_target_aligned;
  logic [XLEN-1:0]   w_next_pc;
  logic [XLEN-1:0]   w_imm;

  // Redirect targets are forced to word alignment.
  assign w_pc_plus4       = r_pc + XLEN'(4);
  assign w_target_aligned = target & 32'hFFFF_FFFC;
  assign w_next_pc        = (Jump | PCSrc) ? w_target_aligned : w_pc_plus4;

  // Control FSM; status outputs are registered alongside the state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= S_FETCH;
      r_pc      <= PC_INIT;
      r_instr   <= '0;
      r_retired <= '0;
      r_iren    <= 1'b1;
      r_valid   <= 1'b0;
      r_halted  <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (ihit) begin
            r_instr <= iload;
            r_state <= S_EXEC;
            r_iren  <= 1'b0;
            r_valid <= 1'b1;
          end
        end
        S_EXEC: begin
          if (!mem_stall) begin
            if (halt) begin
              r_state  <= S_HALTED;
              r_valid  <= 1'b0;
              r_halted <= 1'b1;
            end else begin
              r_retired <= r_retired + XLEN'(1);
              r_pc      <= w_next_pc;
              r_state   <= S_FETCH;
              r_iren    <= 1'b1;
              r_valid   <= 1'b0;
            end
          end
        end
        S_HALTED: begin
          r_state <= S_HALTED;
        end
        default: begin
          r_state  <= S_FETCH;
          r_iren   <= 1'b1;
          r_valid  <= 1'b0;
          r_halted <= 1'b0;
        end
      endcase
    end
  end

  // Immediate generation from the latched instruction only.
  always_comb begin
    w_imm = '0;
    case (r_instr[6:0])
      OPC_OP_IMM, OPC_LOAD, OPC_JALR:
        w_imm = {{20{r_instr[31]}}, r_instr[31:20]};
      OPC_STORE:
        w_imm = {{20{r_instr[31]}}, r_instr[31:25], r_instr[11:7]};
      OPC_BRANCH:
        w_imm = {{19{r_instr[31]}}, r_instr[31], r_instr[7],
                 r_instr[30:25], r_instr[11:8], 1'b0};
      OPC_LUI, OPC_AUIPC:
        w_imm = {r_instr[31:12], 12'b0};
      OPC_JAL:
        w_imm = {{11{r_instr[31]}}, r_instr[31], r_instr[19:12],
                 r_instr[20], r_instr[30:21], 1'b0};
      default:
        w_imm = '0;
    endcase
  end

  assign opcode      = r_instr[6:0];
  assign funct7      = r_instr[31:25];
  assign funct3      = r_instr[14:12];
  assign rs1         = r_instr[19:15];
  assign rs2         = r_instr[24:20];
  assign rd          = r_instr[11:7];
  assign imm         = w_imm;

  assign iREN        = r_iren;
  assign iaddr       = r_pc;
  assign instr_valid = r_valid;
  assign pc          = r_pc;
  assign pc_plus4    = w_pc_plus4;
  assign halted      = r_halted;
  assign retired     = r_retired;

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Directed bench for fetch_decode_unit: a decode/commit vector table plus
// hand sequences for memory wait, stall, halt and reset corner cases.

module tb_fetch_decode_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] iload;
  logic        ihit;
  logic        mem_stall;
  logic [6:0]  opcode;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] imm;
  logic        instr_valid;
  logic        PCSrc, Jump, halt;
  logic [31:0] target;
  logic [31:0] pc, pc_plus4;
  logic        halted;
  logic [31:0] retired;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_pc;
  logic [31:0] exp_ret;

  fetch_decode_unit #(.PC_INIT(32'h0000_0000)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .ihit(ihit),
    .mem_stall(mem_stall),
    .opcode(opcode), .funct7(funct7), .funct3(funct3),
    .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm),
    .instr_valid(instr_valid),
    .PCSrc(PCSrc), .Jump(Jump), .halt(halt), .target(target),
    .pc(pc), .pc_plus4(pc_plus4),
    .halted(halted), .retired(retired)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] word;
    logic        pcsrc;
    logic        jump;
    logic [31:0] tgt;
    logic [6:0]  opc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_reset_state();
    chk("rst_iren", 32'(iREN), 32'd1);
    chk("rst_iaddr", iaddr, 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_opcode", 32'(opcode), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_retired", retired, 32'd0);
  endtask

  initial begin
    //        word          pcsrc jump target         opc       rd  rs1 rs2 f3    f7       imm
    vecs[0] = '{32'h00500093, 1'b0, 1'b0, 32'h0,         7'h13, 5'd1,  5'd0,  5'd5,  3'd0, 7'h00, 32'h0000_0005};
    vecs[1] = '{32'hFE208CE3, 1'b1, 1'b0, 32'h0000_0040, 7'h63, 5'd25, 5'd1,  5'd2,  3'd0, 7'h7F, 32'hFFFF_FFF8};
    vecs[2] = '{32'hFE208CE3, 1'b1, 1'b0, 32'h0000_0043, 7'h63, 5'd25, 5'd1,  5'd2,  3'd0, 7'h7F, 32'hFFFF_FFF8};
    vecs[3] = '{32'h010000EF, 1'b0, 1'b1, 32'h0000_0050, 7'h6F, 5'd1,  5'd0,  5'd16, 3'd0, 7'h00, 32'h0000_0010};
    vecs[4] = '{32'h123452B7, 1'b0, 1'b0, 32'h0000_0100, 7'h37, 5'd5,  5'd8,  5'd3,  3'd5, 7'h09, 32'h1234_5000};
    vecs[5] = '{32'hFE20AE23, 1'b0, 1'b0, 32'h0,         7'h23, 5'd28, 5'd1,  5'd2,  3'd2, 7'h7F, 32'hFFFF_FFFC};
    vecs[6] = '{32'h002081B3, 1'b0, 1'b0, 32'h0,         7'h33, 5'd3,  5'd1,  5'd2,  3'd0, 7'h00, 32'h0000_0000};
    vecs[7] = '{32'hFFF00093, 1'b0, 1'b0, 32'h0,         7'h13, 5'd1,  5'd0,  5'd31, 3'd0, 7'h7F, 32'hFFFF_FFFF};
    vecs[8] = '{32'hFFFFF517, 1'b0, 1'b1, 32'hFFFF_FFFE, 7'h17, 5'd10, 5'd31, 5'd31, 3'd7, 7'h7F, 32'hFFFF_F000};
    vecs[9] = '{32'h00500093, 1'b0, 1'b0, 32'h0,         7'h13, 5'd1,  5'd0,  5'd5,  3'd0, 7'h00, 32'h0000_0005};

    RST = 1'b1; ihit = 1'b1; iload = 32'hDEAD_BEEF; mem_stall = 1'b0;
    PCSrc = 1'b0; Jump = 1'b0; halt = 1'b0; target = 32'h0;
    tick();
    tick();
    chk_reset_state();
    RST = 1'b0; ihit = 1'b0;
    exp_pc = 32'h0; exp_ret = 32'h0;

    // Memory wait: three cycles without ihit.
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("wait_iren", 32'(iREN), 32'd1);
      chk("wait_iaddr", iaddr, exp_pc);
      chk("wait_valid", 32'(instr_valid), 32'd0);
    end

    // Decode and commit table.
    for (int i = 0; i < 10; i++) begin
      iload = vecs[i].word; ihit = 1'b1;
      tick();
      ihit = 1'b0; iload = 32'hDEAD_BEEF;
      #1;
      chk($sformatf("v%0d_valid", i), 32'(instr_valid), 32'd1);
      chk($sformatf("v%0d_iren", i), 32'(iREN), 32'd0);
      chk($sformatf("v%0d_opcode", i), 32'(opcode), 32'(vecs[i].opc));
      chk($sformatf("v%0d_rd", i), 32'(rd), 32'(vecs[i].rd));
      chk($sformatf("v%0d_rs1", i), 32'(rs1), 32'(vecs[i].rs1));
      chk($sformatf("v%0d_rs2", i), 32'(rs2), 32'(vecs[i].rs2));
      chk($sformatf("v%0d_funct3", i), 32'(funct3), 32'(vecs[i].f3));
      chk($sformatf("v%0d_funct7", i), 32'(funct7), 32'(vecs[i].f7));
      chk($sformatf("v%0d_imm", i), imm, vecs[i].imm);
      chk($sformatf("v%0d_pc", i), pc, exp_pc);
      chk($sformatf("v%0d_pc4", i), pc_plus4, exp_pc + 32'd4);
      PCSrc = vecs[i].pcsrc; Jump = vecs[i].jump; target = vecs[i].tgt;
      tick();
      PCSrc = 1'b0; Jump = 1'b0; target = 32'h0;
      exp_pc  = (vecs[i].jump | vecs[i].pcsrc) ? {vecs[i].tgt[31:2], 2'b00} : exp_pc + 32'd4;
      exp_ret = exp_ret + 32'd1;
      chk($sformatf("v%0d_next_iaddr", i), iaddr, exp_pc);
      chk($sformatf("v%0d_retired", i), retired, exp_ret);
      chk($sformatf("v%0d_fetch_iren", i), 32'(iREN), 32'd1);
      chk($sformatf("v%0d_fetch_valid", i), 32'(instr_valid), 32'd0);
    end
    chk("wrap_pc_zero", iaddr, 32'h0);

    // Load held by mem_stall for two cycles; stray ihit must be ignored.
    iload = 32'h0080A303; ihit = 1'b1;
    tick();
    iload = 32'h00500093; mem_stall = 1'b1; halt = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c > 0) tick();
      chk("stall_valid", 32'(instr_valid), 32'd1);
      chk("stall_opcode", 32'(opcode), 32'h03);
      chk("stall_rd", 32'(rd), 32'd6);
      chk("stall_imm", imm, 32'h8);
      chk("stall_pc", pc, exp_pc);
      chk("stall_retired", retired, exp_ret);
    end
    mem_stall = 1'b0; ihit = 1'b0;
    tick();
    exp_pc = exp_pc + 32'd4; exp_ret = exp_ret + 32'd1;
    chk("stall_release_iaddr", iaddr, exp_pc);
    chk("stall_release_retired", retired, exp_ret);
    chk("stall_release_valid", 32'(instr_valid), 32'd0);

    // Halt instruction, then noise on every input.
    iload = 32'hFFFF_FFFF; ihit = 1'b1;
    tick();
    ihit = 1'b0;
    chk("halt_opcode", 32'(opcode), 32'h7F);
    chk("halt_imm", imm, 32'h0);
    halt = 1'b1;
    tick();
    chk("halt_halted", 32'(halted), 32'd1);
    chk("halt_iren", 32'(iREN), 32'd0);
    chk("halt_valid", 32'(instr_valid), 32'd0);
    chk("halt_iaddr", iaddr, exp_pc);
    chk("halt_retired", retired, exp_ret);
    for (int c = 0; c < 6; c++) begin
      ihit = 1'($urandom_range(0, 1)); mem_stall = 1'($urandom_range(0, 1));
      halt = 1'($urandom_range(0, 1)); PCSrc = 1'($urandom_range(0, 1));
      Jump = 1'($urandom_range(0, 1)); target = $urandom; iload = $urandom;
      tick();
      chk("halted_hold", 32'(halted), 32'd1);
      chk("halted_iren", 32'(iREN), 32'd0);
      chk("halted_iaddr", iaddr, exp_pc);
      chk("halted_retired", retired, exp_ret);
    end

    // Reset out of HALTED with ihit asserted.
    RST = 1'b1; ihit = 1'b1; iload = 32'h00500093; halt = 1'b1; mem_stall = 1'b1;
    tick();
    chk_reset_state();
    // Reset coincident with ihit during FETCH: nothing latched.
    tick();
    chk("rstfetch_valid", 32'(instr_valid), 32'd0);
    chk("rstfetch_opcode", 32'(opcode), 32'd0);
    RST = 1'b0; ihit = 1'b0; halt = 1'b0; mem_stall = 1'b0; PCSrc = 1'b0; Jump = 1'b0;
    tick();
    chk("postrst_valid", 32'(instr_valid), 32'd0);
    chk("postrst_iren", 32'(iREN), 32'd1);
    chk("postrst_opcode", 32'(opcode), 32'd0);
    ihit = 1'b1;
    tick();
    ihit = 1'b0;
    chk("postrst_latch_valid", 32'(instr_valid), 32'd1);
    chk("postrst_latch_opcode", 32'(opcode), 32'h13);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
